// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU sharing logic:
//     XLEN_DEFAULT : default operand/result width of alu_64bit
//     alu_op_e     : alu_ctrl opcode encoding understood by alu_64bit
//     arb_state_e  : control states of alu_share_arbiter
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    AND = 4'b0010,
    OR  = 4'b0011,
    SLL = 4'b0101,
    SRA = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first asserted request found when
//   searching upward from last_grant+1, wrapping at N.
// Ports
//   req        in  [N]      request vector
//   last_grant in  [IDX_W]  index granted most recently
//   grant      out [N]      one-hot grant (all zero when no request)
//   grant_idx  out [IDX_W]  index of the granted request (0 when none)
//   grant_any  out 1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // Offsets 1..N visit every requester once, last_grant itself last.
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % N);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one external combinational alu_64bit between NUM_REQ requesters.
//   Round-robin grant, one op in flight: IDLE (accept) -> EXEC (ALU evaluates
//   registered operands) -> RESP (hold result until the granted requester
//   takes it). Accept in cycle N, response valid in cycle N+2.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_a/req_b/req_ctrl     per-requester operands and alu_ctrl code
//   rsp_valid/rsp_ready      per-requester response handshake (valid one-hot)
//   rsp_result/rsp_zero      shared registered result and zero flag
//   alu_a/alu_b/alu_ctrl     to alu_64bit, straight from operand registers
//   alu_result/alu_zero      from alu_64bit
//   grant_cnt                accepted-op count per requester, present only
//                            when ALU_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b,
  input  logic [NUM_REQ-1:0][3:0]       req_ctrl,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [XLEN-1:0]               rsp_result,
  output logic                          rsp_zero,
  output logic [XLEN-1:0]               alu_a,
  output logic [XLEN-1:0]               alu_b,
  output logic [3:0]                    alu_ctrl,
  input  logic [XLEN-1:0]               alu_result,
  input  logic                          alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] gsel_p0;
  logic [XLEN-1:0]  op_a_p0, op_b_p0;
  logic [3:0]       op_ctrl_p0;
  logic [XLEN-1:0]  res_p1;
  logic             zero_p1;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               accept;
  logic               rsp_hs;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx),
    .grant_any  (gnt_any)
  );

  assign accept = (state_q == IDLE) && gnt_any;
  assign rsp_hs = (state_q == RESP) && rsp_ready[gsel_p0];

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready = gnt_oh;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[gsel_p0] = 1'b1;
        if (rsp_ready[gsel_p0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      gsel_p0      <= '0;
      op_a_p0      <= '0;
      op_b_p0      <= '0;
      op_ctrl_p0   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gsel_p0    <= gnt_idx;
        op_a_p0    <= req_a[gnt_idx];
        op_b_p0    <= req_b[gnt_idx];
        op_ctrl_p0 <= req_ctrl[gnt_idx];
      end
      if (rsp_hs) last_grant_q <= gsel_p0;
    end
  end

  // Stage p1: ALU result capture at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1  <= '0;
      zero_p1 <= 1'b0;
    end else if (state_q == EXEC) begin
      res_p1  <= alu_result;
      zero_p1 <= alu_zero;
    end
  end

  assign alu_a      = op_a_p0;
  assign alu_b      = op_b_p0;
  assign alu_ctrl   = op_ctrl_p0;
  assign rsp_result = res_p1;
  assign rsp_zero   = zero_p1;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Bench for alu_share_arbiter with NUM_REQ=2, XLEN=64 and a behavioural
//   alu_64bit on the alu_* ports. Expected responses are queued when an op is
//   accepted and retired when a response handshake is seen.
//   Define ALU_ARB_STATS_EN to also exercise grant_cnt.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NR = 2;
  localparam int XL = 64;
  localparam int CW = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][XL-1:0]    req_a;
  logic [NR-1:0][XL-1:0]    req_b;
  logic [NR-1:0][3:0]       req_ctrl;
  logic [NR-1:0]            rsp_valid;
  logic [NR-1:0]            rsp_ready;
  logic [XL-1:0]            rsp_result;
  logic                     rsp_zero;
  logic [XL-1:0]            alu_a, alu_b;
  logic [3:0]               alu_ctrl;
  logic [XL-1:0]            alu_result;
  logic                     alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic [NR-1:0][CW-1:0]    grant_cnt;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NR), .XLEN(XL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  // Behavioural alu_64bit
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ADD:     alu_result = alu_a + alu_b;
      SUB:     alu_result = alu_a - alu_b;
      AND:     alu_result = alu_a & alu_b;
      OR:      alu_result = alu_a | alu_b;
      SLL:     alu_result = alu_a << alu_b[5:0];
      SRA:     alu_result = $unsigned($signed(alu_a) >>> alu_b[5:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct {
    int          idx;
    logic [63:0] res;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: retire one scoreboard entry per response handshake
  always @(negedge clk) begin
    if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rsp_idx", 64'(rsp_valid), 64'(1) << sb_e.idx);
        chk("rsp_result", rsp_result, sb_e.res);
        chk("rsp_zero", 64'(rsp_zero), 64'(sb_e.zero));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one op on requester r, check accept, exec bubble and response latency.
  task automatic run_op(input int r, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] ctrl, input logic [63:0] er, input logic ez);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_a[r]     = a;
    req_b[r]     = b;
    req_ctrl[r]  = ctrl;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
    end
    chk("accept", 64'(ok), 64'd1);
    if (ok) begin
      chk("req_ready_onehot", 64'(req_ready), 64'(1) << r);
      sb_q.push_back('{r, er, ez});
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      @(negedge clk);
      chk("exec_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("rsp_latency", 64'(rsp_valid), 64'(1) << r);
    end else begin
      req_valid[r] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          gi;
    logic [63:0] ra, rb;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ops on each requester
    run_op(0, 64'd2, 64'd3, ADD, 64'd5, 1'b0);
    run_op(1, 64'd5, 64'd5, SUB, 64'd0, 1'b1);

    // Both requesters valid continuously: strict alternation from requester 0
    do_reset();
    req_a[0] = {8{8'hF0}}; req_b[0] = {8{8'h0F}}; req_ctrl[0] = AND;
    req_a[1] = {8{8'hAA}}; req_b[1] = {8{8'h55}}; req_ctrl[1] = OR;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge clk);
        if (req_ready != '0) ok = 1'b1;
      end
      chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      gi = req_ready[1] ? 1 : 0;
      if (ok) begin
        if (gi == 0) sb_q.push_back('{0, 64'd0, 1'b1});
        else         sb_q.push_back('{1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      end
      @(posedge clk);
    end
    #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Response back-pressure: held result, other requester locked out
    #1 rsp_ready = 2'b10;
    run_op(0, 64'd1, 64'd2, SLL, 64'd4, 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_a[1] = 64'd40; req_b[1] = 64'd2; req_ctrl[1] = ADD;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_result", rsp_result, 64'd4);
      chk("hold_no_accept", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    run_op(1, 64'd40, 64'd2, ADD, 64'd42, 1'b0);

    // Reset in the middle of EXEC drops the op
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_a[0] = 64'h8000_0000_0000_0000; req_b[0] = 64'd1; req_ctrl[0] = SRA;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[0]) ok = 1'b1;
    end
    chk("sra_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("exec_alu_a", alu_a, 64'h8000_0000_0000_0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_result", rsp_result, 64'd0);
    chk("midrst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("midrst_alu_a", alu_a, 64'd0);
    chk("midrst_alu_b", alu_b, 64'd0);
    chk("midrst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(0, 64'd7, 64'd8, ADD, 64'd15, 1'b0);

    // Random ADD/SUB traffic alternating requesters
    for (int k = 0; k < 6; k++) begin
      ra = {$urandom, $urandom};
      rb = (k == 5) ? ra : {$urandom, $urandom};
      if (k % 2 == 0) run_op(k % 2, ra, rb, ADD, ra + rb, (ra + rb) == 64'd0);
      else            run_op(k % 2, ra, rb, SUB, ra - rb, ra == rb);
    end

`ifdef ALU_ARB_STATS_EN
    do_reset();
    run_op(0, 64'd1, 64'd1, ADD, 64'd2, 1'b0);
    run_op(1, 64'd1, 64'd1, ADD, 64'd2, 1'b0);
    run_op(0, 64'd3, 64'd1, SUB, 64'd2, 1'b0);
    run_op(1, 64'd6, 64'd3, OR,  64'd7, 1'b0);
    run_op(0, 64'd6, 64'd3, AND, 64'd2, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("grant_cnt0", 64'(grant_cnt[0]), 64'd3);
    chk("grant_cnt1", 64'(grant_cnt[1]), 64'd2);
    do_reset();
    @(negedge clk);
    chk("grant_cnt0_rst", 64'(grant_cnt[0]), 64'd0);
    chk("grant_cnt1_rst", 64'(grant_cnt[1]), 64'd0);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
